light_driver: RTL and testbench

- Actuator-side partner of light_control: consumes its int_light request and physically drives the internal lamp.
- Applies a soft fade-in / fade-out brightness ramp, an off-hold delay that rides over brief request drops, and a PWM output stage.
- Sits between light_control and the lamp power stage; a manual override path allows direct on/off commands.

---
 rtl/light_driver_pkg.sv | 21 ++
 rtl/light_driver_pwm_gen.sv | 30 +++
 rtl/light_driver.sv | 130 +++++++++++++
 tb/tb_light_driver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/light_driver_pkg.sv
// ============================================================================
// light_driver_pkg : shared lamp-driver state encoding and default widths
// Rev 1.0
// ============================================================================
`default_nettype none

package light_driver_pkg;

    localparam int DEFAULT_PWM_BITS = 8;

    typedef enum logic [2:0] {
        LD_OFF       = 3'd0,
        LD_FADE_UP   = 3'd1,
        LD_ON        = 3'd2,
        LD_HOLD      = 3'd3,
        LD_FADE_DOWN = 3'd4
    } ld_state_t;

endpackage

`default_nettype wire

// File: rtl/light_driver_pwm_gen.sv
// ============================================================================
// pwm_gen : free-running counter with registered duty compare against level
// Rev 1.0
// ============================================================================
`default_nettype none

module pwm_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic             pwm_out
);

    logic [WIDTH-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_out <= (pwm_cnt < level);
        end
    end

endmodule

`default_nettype wire

// File: rtl/light_driver.sv
// ============================================================================
// light_driver : lamp fade-in/fade-out ramp with off-hold and PWM output stage
// Rev 1.0
// ============================================================================
`default_nettype none

module light_driver
    import light_driver_pkg::*;
#(
    parameter int PWM_BITS    = DEFAULT_PWM_BITS,
    parameter int STEP_CYCLES = 4,
    parameter int OFF_HOLD    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                int_light,
    input  logic                manual,
    input  logic                manual_on,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] level,
    output logic                busy,
    output logic                lamp_on
);

    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int HW = (OFF_HOLD > 1) ? $clog2(OFF_HOLD) : 1;
    localparam logic [PWM_BITS-1:0] MAXL      = '1;
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [HW-1:0]       HOLD_INIT = HW'(OFF_HOLD - 1);

    ld_state_t             state;
    logic [SW-1:0]         step_cnt;
    logic [HW-1:0]         hold_cnt;
    logic                  req;
    logic                  tick;
    logic [PWM_BITS-1:0]   level_up;
    logic [PWM_BITS-1:0]   level_dn;

    assign req  = manual ? manual_on : int_light;
    assign tick = (step_cnt == STEP_LAST);

    // Saturating neighbours keep the ramp from wrapping when a fade is
    // reversed right at an end stop.
    assign level_up = (level == MAXL) ? MAXL : level + 1'b1;
    assign level_dn = (level == '0)   ? '0   : level - 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= LD_OFF;
            level    <= '0;
            step_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                LD_OFF: begin
                    if (req) begin
                        state    <= LD_FADE_UP;
                        step_cnt <= '0;
                    end
                end
                LD_FADE_UP: begin
                    if (!req) begin
                        state    <= LD_FADE_DOWN;
                        step_cnt <= '0;
                    end else if (tick) begin
                        level    <= level_up;
                        step_cnt <= '0;
                        if (level_up == MAXL) state <= LD_ON;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                LD_ON: begin
                    if (!req) begin
                        step_cnt <= '0;
                        if (manual) begin
                            state <= LD_FADE_DOWN;
                        end else begin
                            state    <= LD_HOLD;
                            hold_cnt <= HOLD_INIT;
                        end
                    end
                end
                LD_HOLD: begin
                    if (req) begin
                        state <= LD_ON;
                    end else if (hold_cnt == '0) begin
                        state    <= LD_FADE_DOWN;
                        step_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                LD_FADE_DOWN: begin
                    if (req) begin
                        state    <= LD_FADE_UP;
                        step_cnt <= '0;
                    end else if (tick) begin
                        level    <= level_dn;
                        step_cnt <= '0;
                        if (level_dn == '0) state <= LD_OFF;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= LD_OFF;
                    level    <= '0;
                    step_cnt <= '0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign busy    = (state == LD_FADE_UP) || (state == LD_FADE_DOWN);
    assign lamp_on = (level != '0);

    pwm_gen #(
        .WIDTH (PWM_BITS)
    ) u_pwm_gen (
        .clk     (clk),
        .reset   (reset),
        .level   (level),
        .pwm_out (pwm_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_light_driver.sv
// ============================================================================
// tb_light_driver : directed + random checks of light_driver against a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_light_driver;

    localparam int PB   = 4;
    localparam int STEP = 1;
    localparam int HOLD = 3;
    localparam int MAXL = (1 << PB) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          int_light;
    logic          manual;
    logic          manual_on;
    logic          pwm_out;
    logic [PB-1:0] level;
    logic          busy;
    logic          lamp_on;

    int total = 0;
    int bad   = 0;

    // Model: direction of travel (+1/-1/0), edges since last ramp step,
    // consecutive low-request edges while at full brightness, edge count.
    int m_lvl, m_dir, m_phase, m_low, m_edges;
    bit m_pwm;

    light_driver #(
        .PWM_BITS    (PB),
        .STEP_CYCLES (STEP),
        .OFF_HOLD    (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .int_light (int_light),
        .manual    (manual),
        .manual_on (manual_on),
        .pwm_out   (pwm_out),
        .level     (level),
        .busy      (busy),
        .lamp_on   (lamp_on)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_lvl = 0; m_dir = 0; m_phase = 0; m_low = 0; m_edges = 0; m_pwm = 1'b0;
    endfunction

    function automatic void model_edge(input bit rq, input bit man);
        m_pwm = ((m_edges % (1 << PB)) < m_lvl);
        m_edges++;
        if (m_dir == 0 && m_lvl == 0) begin
            if (rq) begin m_dir = 1; m_phase = 0; end
        end else if (m_dir == 0) begin
            if (rq) begin
                m_low = 0;
            end else if (m_low == 0 && man) begin
                m_dir = -1; m_phase = 0;
            end else begin
                m_low++;
                if (m_low == HOLD + 1) begin
                    m_dir = -1; m_phase = 0; m_low = 0;
                end
            end
        end else if ((m_dir > 0) != rq) begin
            m_dir = -m_dir; m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == STEP) begin
                m_phase = 0;
                m_lvl = m_lvl + m_dir;
                if (m_lvl > MAXL) m_lvl = MAXL;
                if (m_lvl < 0)    m_lvl = 0;
                if ((m_dir > 0 && m_lvl == MAXL) || (m_dir < 0 && m_lvl == 0)) m_dir = 0;
            end
        end
    endfunction

    task automatic cycle();
        bit rq;
        @(posedge clk);
        rq = manual ? manual_on : int_light;
        model_edge(rq, manual);
        @(negedge clk);
        chk("level",   32'(level),   32'(m_lvl));
        chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
        chk("busy",    32'(busy),    32'(m_dir != 0));
        chk("lamp_on", 32'(lamp_on), 32'(m_lvl != 0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to_level(input string tag, input int target);
        int n = 0;
        while (level != target && n < 60) begin
            cycle();
            n++;
        end
        chk(tag, 32'(level), 32'(target));
    endtask

    initial begin
        int hi;
        reset = 1'b0; int_light = 1'b1; manual = 1'b0; manual_on = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_level",   32'(level),   0);
        chk("rst_pwm",     32'(pwm_out), 0);
        chk("rst_busy",    32'(busy),    0);
        chk("rst_lamp_on", 32'(lamp_on), 0);

        reset = 1'b1;
        run(15);
        chk("up_not_done", 32'(busy), 1);
        run(1);
        chk("up_level", 32'(level), 15);
        chk("up_busy",  32'(busy),  0);

        // brief drop rides through the hold window
        int_light = 1'b0; run(2);
        int_light = 1'b1; run(3);
        chk("ride_level", 32'(level), 15);
        int_light = 1'b0; run(3);
        chk("hold_busy", 32'(busy), 0);
        run(1);
        chk("hold_expire", 32'(busy), 1);
        run(15);
        chk("down_level",   32'(level),   0);
        chk("down_lamp_on", 32'(lamp_on), 0);

        // reversal mid-fade
        int_light = 1'b1; run_to_level("rev_up7", 7);
        int_light = 1'b0; run_to_level("rev_dn4", 4);
        int_light = 1'b1; run(1);
        chk("rev_nojump", 32'(level), 4);
        run_to_level("rev_full", 15);

        // manual override
        manual = 1'b1; manual_on = 1'b0; run(1);
        chk("man_off_busy", 32'(busy), 1);
        run_to_level("man_off_zero", 0);
        manual_on = 1'b1; run_to_level("man_on_full", 15);
        run(1);
        manual_on = 1'b0; run(1);
        chk("man_no_hold", 32'(busy), 1);
        run(1);
        chk("man_dec", 32'(level), 14);

        // duty at full brightness
        manual_on = 1'b1; run_to_level("duty_full", 15);
        run(2);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            hi += int'(pwm_out);
        end
        chk("duty15", 32'(hi), 15);

        // async reset mid-fade
        manual_on = 1'b0; run_to_level("ar_zero", 0);
        manual_on = 1'b1; run_to_level("ar_nine", 9);
        #2 reset = 1'b0;
        #1;
        chk("ar_level",   32'(level),   0);
        chk("ar_pwm",     32'(pwm_out), 0);
        chk("ar_busy",    32'(busy),    0);
        chk("ar_lamp_on", 32'(lamp_on), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // randomized request bursts
        for (int b = 0; b < 300; b++) begin
            manual    = ($urandom_range(0, 3) == 0);
            manual_on = $urandom_range(0, 1);
            int_light = $urandom_range(0, 1);
            run($urandom_range(1, 25));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
